flow_ctrl: RTL and testbench

Pipeline flow controller for the rooth core. Each cycle it drives the `FLOW_WORK` / `FLOW_STOP` / `FLOW_REFRESH` codes into the PC register and every inter-stage register (if_de, de_ex, ex_mem, mem_wb). It resolves these hazard sources:

- load-use hazards
- taken jumps/branches
- multi-cycle divide
- memory-bus wait states

It also keeps a stall-cycle performance counter and a divide watchdog.

---
 rtl/flow_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_flow_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/flow_ctrl.sv
// Pipeline flow controller: drives WORK/STOP/REFRESH codes into PC and inter-stage registers.
// Latency: flow codes and pc_sel are combinational (same cycle); state, counters, busy are registered.
// Backpressure: a bus wait freezes PC..EX/MEM and bubbles MEM/WB; divide and load-use stall the front end.

`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef FLOW_WIDTH
`define FLOW_WIDTH 2
`endif
`ifndef FLOW_WORK
`define FLOW_WORK 2'd0
`endif
`ifndef FLOW_STOP
`define FLOW_STOP 2'd1
`endif
`ifndef FLOW_REFRESH
`define FLOW_REFRESH 2'd2
`endif

module flow_ctrl #(
  parameter int DIV_TIMEOUT = 64,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ld_use_hazard_i,
  input  logic                   jump_taken_i,
  input  logic [`CPU_WIDTH-1:0]  jump_addr_i,
  input  logic                   div_start_i,
  input  logic                   div_done_i,
  input  logic                   mem_req_i,
  input  logic                   mem_ready_i,
  output logic [`FLOW_WIDTH-1:0] flow_pc_o,
  output logic [`FLOW_WIDTH-1:0] flow_if_de_o,
  output logic [`FLOW_WIDTH-1:0] flow_de_ex_o,
  output logic [`FLOW_WIDTH-1:0] flow_ex_mem_o,
  output logic [`FLOW_WIDTH-1:0] flow_mem_wb_o,
  output logic                   pc_sel_o,
  output logic [`CPU_WIDTH-1:0]  jump_addr_o,
  output logic                   div_busy_o,
  output logic                   div_err_o,
  output logic [CNT_WIDTH-1:0]   stall_cnt_o
);

  // Counter only needs to reach DIV_TIMEOUT-1; the abort fires there.
  localparam int DW = (DIV_TIMEOUT > 2) ? $clog2(DIV_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LD_STALL = 2'd1,
    ST_DIV_WAIT = 2'd2
  } state_t;

  state_t                 r_state;
  logic [DW-1:0]          r_div_cnt;
  logic                   r_done_pend;
  logic [CNT_WIDTH-1:0]   r_stall_cnt;

  logic                   w_bus_wait;
  logic                   w_div_fin;
  logic                   w_div_abort;
  logic                   w_pc_sel;

  // Event decode shared by the flow logic and the state register.
  always_comb begin
    w_bus_wait  = mem_req_i & ~mem_ready_i;
    w_div_fin   = (r_state == ST_DIV_WAIT) & (div_done_i | r_done_pend);
    w_div_abort = (r_state == ST_DIV_WAIT) & ~w_div_fin &
                  (r_div_cnt == DW'(DIV_TIMEOUT - 1));
  end

  // Flow codes: reset refresh, then bus wait override, then per-state hazard handling.
  always_comb begin
    flow_pc_o     = `FLOW_WORK;
    flow_if_de_o  = `FLOW_WORK;
    flow_de_ex_o  = `FLOW_WORK;
    flow_ex_mem_o = `FLOW_WORK;
    flow_mem_wb_o = `FLOW_WORK;
    w_pc_sel      = 1'b0;
    if (!rst_n) begin
      flow_pc_o     = `FLOW_REFRESH;
      flow_if_de_o  = `FLOW_REFRESH;
      flow_de_ex_o  = `FLOW_REFRESH;
      flow_ex_mem_o = `FLOW_REFRESH;
      flow_mem_wb_o = `FLOW_REFRESH;
    end else if (w_bus_wait) begin
      flow_pc_o     = `FLOW_STOP;
      flow_if_de_o  = `FLOW_STOP;
      flow_de_ex_o  = `FLOW_STOP;
      flow_ex_mem_o = `FLOW_STOP;
      flow_mem_wb_o = `FLOW_REFRESH;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (jump_taken_i) begin
            w_pc_sel     = 1'b1;
            flow_if_de_o = `FLOW_REFRESH;
            flow_de_ex_o = `FLOW_REFRESH;
          end else if (div_start_i) begin
            // Divide issues this cycle; stalling begins next cycle.
          end else if (ld_use_hazard_i) begin
            flow_pc_o    = `FLOW_STOP;
            flow_if_de_o = `FLOW_STOP;
            flow_de_ex_o = `FLOW_REFRESH;
          end
        end
        ST_LD_STALL: begin
          // The single bubble is already inserted; only a jump changes the flow.
          if (jump_taken_i) begin
            w_pc_sel     = 1'b1;
            flow_if_de_o = `FLOW_REFRESH;
            flow_de_ex_o = `FLOW_REFRESH;
          end
        end
        ST_DIV_WAIT: begin
          if (!w_div_fin && !w_div_abort) begin
            flow_pc_o     = `FLOW_STOP;
            flow_if_de_o  = `FLOW_STOP;
            flow_de_ex_o  = `FLOW_STOP;
            flow_ex_mem_o = `FLOW_REFRESH;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Control/status outputs; everything is forced quiet while reset is asserted.
  always_comb begin
    pc_sel_o    = w_pc_sel;
    jump_addr_o = w_pc_sel ? jump_addr_i : '0;
    div_busy_o  = rst_n & (r_state == ST_DIV_WAIT);
    div_err_o   = rst_n & ~w_bus_wait & w_div_abort;
    stall_cnt_o = r_stall_cnt;
  end

  // FSM, divide watchdog counter, pending-done flag and saturating stall counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_div_cnt   <= '0;
      r_done_pend <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      if ((flow_pc_o == `FLOW_STOP) && (r_stall_cnt != {CNT_WIDTH{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
      end
      if (w_bus_wait) begin
        // Everything holds; a done that lands during the wait is remembered.
        if ((r_state == ST_DIV_WAIT) && div_done_i) begin
          r_done_pend <= 1'b1;
        end
      end else begin
        case (r_state)
          ST_RUN: begin
            if (!jump_taken_i && div_start_i) begin
              r_state     <= ST_DIV_WAIT;
              r_div_cnt   <= '0;
              r_done_pend <= 1'b0;
            end else if (!jump_taken_i && ld_use_hazard_i) begin
              r_state <= ST_LD_STALL;
            end
          end
          ST_LD_STALL: begin
            r_state <= ST_RUN;
          end
          ST_DIV_WAIT: begin
            if (w_div_fin || w_div_abort) begin
              r_state     <= ST_RUN;
              r_done_pend <= 1'b0;
            end else begin
              r_div_cnt <= r_div_cnt + DW'(1);
            end
          end
          default: begin
            r_state <= ST_RUN;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_flow_ctrl.sv
// Scoreboard bench for flow_ctrl: driver queues per-cycle expectations, a negedge monitor checks them.
// Runs with DIV_TIMEOUT=8 and CNT_WIDTH=4 so watchdog and saturation are reachable quickly.
// Flow encoding assumed: WORK=0, STOP=1, REFRESH=2.

module tb_flow_ctrl;

  localparam logic [1:0] W = 2'd0;
  localparam logic [1:0] S = 2'd1;
  localparam logic [1:0] R = 2'd2;

  // Packed as {pc, if_de, de_ex, ex_mem, mem_wb}
  localparam logic [9:0] ALLW = {W, W, W, W, W};
  localparam logic [9:0] ALLR = {R, R, R, R, R};
  localparam logic [9:0] BUSW = {S, S, S, S, R};
  localparam logic [9:0] LDST = {S, S, R, W, W};
  localparam logic [9:0] JMP  = {W, R, R, W, W};
  localparam logic [9:0] DIVW = {S, S, S, R, W};

  // Packed as {ld_use, jump_taken, div_start, div_done, mem_req, mem_ready}
  localparam logic [5:0] I_NONE = 6'b000000;
  localparam logic [5:0] I_LD   = 6'b100000;
  localparam logic [5:0] I_JT   = 6'b010000;
  localparam logic [5:0] I_DS   = 6'b001000;
  localparam logic [5:0] I_DD   = 6'b000100;
  localparam logic [5:0] I_MR   = 6'b000010;
  localparam logic [5:0] I_RDY  = 6'b000001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_use_hazard_i, jump_taken_i, div_start_i, div_done_i, mem_req_i, mem_ready_i;
  logic [31:0] jump_addr_i;
  logic [1:0]  flow_pc_o, flow_if_de_o, flow_de_ex_o, flow_ex_mem_o, flow_mem_wb_o;
  logic        pc_sel_o, div_busy_o, div_err_o;
  logic [31:0] jump_addr_o;
  logic [3:0]  stall_cnt_o;

  typedef struct {
    string       tag;
    logic [9:0]  flows;
    logic        sel;
    logic [31:0] ja;
    logic        busy;
    logic        err;
    int          cnt;   // -1: not checked this cycle
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  flow_ctrl #(.DIV_TIMEOUT(8), .CNT_WIDTH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ld_use_hazard_i(ld_use_hazard_i),
    .jump_taken_i   (jump_taken_i),
    .jump_addr_i    (jump_addr_i),
    .div_start_i    (div_start_i),
    .div_done_i     (div_done_i),
    .mem_req_i      (mem_req_i),
    .mem_ready_i    (mem_ready_i),
    .flow_pc_o      (flow_pc_o),
    .flow_if_de_o   (flow_if_de_o),
    .flow_de_ex_o   (flow_de_ex_o),
    .flow_ex_mem_o  (flow_ex_mem_o),
    .flow_mem_wb_o  (flow_mem_wb_o),
    .pc_sel_o       (pc_sel_o),
    .jump_addr_o    (jump_addr_o),
    .div_busy_o     (div_busy_o),
    .div_err_o      (div_err_o),
    .stall_cnt_o    (stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input string field, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s.%s: got 0x%0h, expected 0x%0h (t=%0t)", tag, field, act, exp, $time);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare mid-cycle against the queued expectation.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.tag, "flows", {22'd0, flow_pc_o, flow_if_de_o, flow_de_ex_o, flow_ex_mem_o, flow_mem_wb_o},
          {22'd0, e.flows});
      chk(e.tag, "pc_sel", {31'd0, pc_sel_o}, {31'd0, e.sel});
      chk(e.tag, "jump_addr", jump_addr_o, e.ja);
      chk(e.tag, "div_busy", {31'd0, div_busy_o}, {31'd0, e.busy});
      chk(e.tag, "div_err", {31'd0, div_err_o}, {31'd0, e.err});
      if (e.cnt >= 0) chk(e.tag, "stall_cnt", {28'd0, stall_cnt_o}, e.cnt);
    end
  end

  // Drive one cycle of inputs and queue the expected response for that cycle.
  task automatic cyc(input string tag, input logic rst, input logic [5:0] in, input logic [31:0] jin,
                     input logic [9:0] fl, input logic sel, input logic [31:0] jexp,
                     input logic busy, input logic err, input int cnt);
    exp_t e;
    rst_n = rst;
    {ld_use_hazard_i, jump_taken_i, div_start_i, div_done_i, mem_req_i, mem_ready_i} = in;
    jump_addr_i = jin;
    e.tag = tag; e.flows = fl; e.sel = sel; e.ja = jexp; e.busy = busy; e.err = err; e.cnt = cnt;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic rst_cycle(input string tag);
    cyc(tag, 1'b0, 6'($urandom), $urandom, ALLR, 1'b0, 32'h0, 1'b0, 1'b0, -1);
  endtask

  initial begin
    rst_n = 1'b0;
    {ld_use_hazard_i, jump_taken_i, div_start_i, div_done_i, mem_req_i, mem_ready_i} = I_NONE;
    jump_addr_i = '0;
    @(posedge clk);
    #1;

    // Reset with random inputs, then first released cycle is all WORK.
    rst_cycle("rst0");
    cyc("rst1", 1'b0, 6'($urandom), $urandom, ALLR, 1'b0, 32'h0, 1'b0, 1'b0, 0);
    cyc("rst2", 1'b0, 6'($urandom), $urandom, ALLR, 1'b0, 32'h0, 1'b0, 1'b0, 0);
    cyc("rel",  1'b1, I_NONE, 32'h0, ALLW, 1'b0, 32'h0, 1'b0, 1'b0, 0);

    // Load-use: exactly one bubble, then back in RUN (a new hazard stalls again).
    cyc("ld0", 1'b1, I_LD,   32'h0, LDST, 1'b0, 32'h0, 1'b0, 1'b0, 0);
    cyc("ld1", 1'b1, I_LD,   32'h0, ALLW, 1'b0, 32'h0, 1'b0, 1'b0, 1);
    cyc("ld2", 1'b1, I_LD,   32'h0, LDST, 1'b0, 32'h0, 1'b0, 1'b0, 1);
    cyc("ld3", 1'b1, I_NONE, 32'h0, ALLW, 1'b0, 32'h0, 1'b0, 1'b0, 2);

    // Jump beats divide and load-use; state stays RUN; address gated when not selected.
    cyc("jmp0", 1'b1, I_JT | I_LD | I_DS, 32'h0000_0100, JMP, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 2);
    cyc("jmp1", 1'b1, I_NONE, 32'h0000_0100, ALLW, 1'b0, 32'h0, 1'b0, 1'b0, 2);
    // Bus wait overrides a jump.
    cyc("jbw0", 1'b1, I_JT | I_MR, 32'h0000_0200, BUSW, 1'b0, 32'h0, 1'b0, 1'b0, 2);
    cyc("jbw1", 1'b1, I_NONE, 32'h0, ALLW, 1'b0, 32'h0, 1'b0, 1'b0, 3);

    // Divide: done arrives under a 3-cycle bus wait, completes on the first free cycle.
    rst_cycle("rst_d");
    cyc("div0", 1'b1, I_DS, 32'h0, ALLW, 1'b0, 32'h0, 1'b0, 1'b0, 0);
    for (int k = 1; k <= 4; k++)
      cyc("divw", 1'b1, I_NONE, 32'h0, DIVW, 1'b0, 32'h0, 1'b1, 1'b0, k - 1);
    cyc("divbw5", 1'b1, I_MR | I_DD, 32'h0, BUSW, 1'b0, 32'h0, 1'b1, 1'b0, 4);
    cyc("divbw6", 1'b1, I_MR,        32'h0, BUSW, 1'b0, 32'h0, 1'b1, 1'b0, 5);
    cyc("divbw7", 1'b1, I_MR,        32'h0, BUSW, 1'b0, 32'h0, 1'b1, 1'b0, 6);
    cyc("divfin", 1'b1, I_MR | I_RDY, 32'h0, ALLW, 1'b0, 32'h0, 1'b1, 1'b0, 7);
    cyc("divpost", 1'b1, I_NONE,      32'h0, ALLW, 1'b0, 32'h0, 1'b0, 1'b0, 7);

    // Watchdog: abort on the 8th DIV_WAIT cycle.
    rst_cycle("rst_w");
    cyc("wd0", 1'b1, I_DS, 32'h0, ALLW, 1'b0, 32'h0, 1'b0, 1'b0, 0);
    for (int k = 1; k <= 7; k++)
      cyc("wdw", 1'b1, I_NONE, 32'h0, DIVW, 1'b0, 32'h0, 1'b1, 1'b0, k - 1);
    cyc("wdabort", 1'b1, I_NONE, 32'h0, ALLW, 1'b0, 32'h0, 1'b1, 1'b1, 7);
    cyc("wdpost",  1'b1, I_NONE, 32'h0, ALLW, 1'b0, 32'h0, 1'b0, 1'b0, 7);

    // Reset mid-divide: abandoned silently, no stale busy afterwards.
    rst_cycle("rst_m");
    cyc("md0", 1'b1, I_DS,   32'h0, ALLW, 1'b0, 32'h0, 1'b0, 1'b0, 0);
    cyc("md1", 1'b1, I_NONE, 32'h0, DIVW, 1'b0, 32'h0, 1'b1, 1'b0, 0);
    cyc("md2", 1'b1, I_NONE, 32'h0, DIVW, 1'b0, 32'h0, 1'b1, 1'b0, 1);
    rst_cycle("md_rst");
    cyc("md3", 1'b1, I_NONE, 32'h0, ALLW, 1'b0, 32'h0, 1'b0, 1'b0, 0);
    cyc("md4", 1'b1, I_DD,   32'h0, ALLW, 1'b0, 32'h0, 1'b0, 1'b0, 0);

    // Saturation: 20 stall cycles into a 4-bit counter.
    rst_cycle("rst_s");
    for (int i = 0; i < 20; i++)
      cyc("sat", 1'b1, I_MR, 32'h0, BUSW, 1'b0, 32'h0, 1'b0, 1'b0, (i < 15) ? i : 15);
    cyc("sat_end0", 1'b1, I_NONE, 32'h0, ALLW, 1'b0, 32'h0, 1'b0, 1'b0, 15);
    cyc("sat_end1", 1'b1, I_NONE, 32'h0, ALLW, 1'b0, 32'h0, 1'b0, 1'b0, 15);

    // Let the monitor drain, bounded.
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
